// File: rtl/vh_pkg.sv
// Shared definitions for the stimulus generator: operand field layout, corner
// operands, LFSR feedback mask, FSM states and LFSR step helper.
package vh_pkg;

  localparam int VEC_W  = 30;
  localparam int LFSR_W = 32;

  localparam int U4_OFF = 0;
  localparam int U4_W   = 4;
  localparam int U5_OFF = 4;
  localparam int U5_W   = 5;
  localparam int U6_OFF = 9;
  localparam int U6_W   = 6;
  localparam int S4_OFF = 15;
  localparam int S4_W   = 4;
  localparam int S5_OFF = 19;
  localparam int S5_W   = 5;
  localparam int S6_OFF = 24;
  localparam int S6_W   = 6;

  // Signed fields at their most negative / most positive, unsigned fields 0 / all-ones.
  localparam logic [VEC_W-1:0] CORNER_SMIN = 30'h20840000;
  localparam logic [VEC_W-1:0] CORNER_SMAX = 30'h1F7BFFFF;
  localparam logic [VEC_W-1:0] CORNER_ONES = 30'h3FFFFFFF;

  localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h00400007;

  typedef enum logic [1:0] {IDLE, CORNER, RANDOM, DONE} state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_MASK : '0);
  endfunction

  function automatic logic [VEC_W-1:0] corner_a(input logic [1:0] idx);
    case (idx)
      2'd0:    return '0;
      2'd1:    return CORNER_ONES;
      2'd2:    return CORNER_SMIN;
      default: return CORNER_SMAX;
    endcase
  endfunction

  function automatic logic [VEC_W-1:0] corner_b(input logic [1:0] idx);
    case (idx)
      2'd0:    return '0;
      2'd1:    return CORNER_ONES;
      2'd2:    return CORNER_SMAX;
      default: return CORNER_SMIN;
    endcase
  endfunction

endpackage

// File: rtl/vh_lfsr32.sv
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1) with synchronous load and step enable;
// exposes the low operand bits of the current and next state.
module vh_lfsr32
  import vh_pkg::*;
#(
  parameter logic [LFSR_W-1:0] INIT = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [VEC_W-1:0]  vec,
  output logic [VEC_W-1:0]  vec_next
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] state_next;

  assign state_next = lfsr_next(state);
  assign vec        = state[VEC_W-1:0];
  assign vec_next   = state_next[VEC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/vh_stim_gen.sv
// Operand stimulus generator: four corner vectors followed by LFSR-driven random
// vectors, presented over a valid/ready handshake with registered outputs.
module vh_stim_gen
  import vh_pkg::*;
#(
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter logic [15:0] NUM_VEC = 16'd1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [VEC_W-1:0] a,
  output logic [VEC_W-1:0] b,
  output logic [15:0]      vec_idx
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1 for A.
  localparam logic [LFSR_W-1:0] SEED_A = (SEED == '0) ? 32'h0000_0001 : SEED;
  localparam logic [LFSR_W-1:0] SEED_B = ~SEED;

  state_t           state;
  logic             start_ok;
  logic             xfer;
  logic             last;
  logic [VEC_W-1:0] lfsr_a_vec;
  logic [VEC_W-1:0] lfsr_a_next;
  logic [VEC_W-1:0] lfsr_b_vec;
  logic [VEC_W-1:0] lfsr_b_next;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign xfer     = vec_valid && vec_ready;
  assign last     = (vec_idx == NUM_VEC - 16'd1);

  vh_lfsr32 #(.INIT(SEED_A)) u_lfsr_a (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .step     (xfer && (state == RANDOM)),
    .seed     (SEED_A),
    .vec      (lfsr_a_vec),
    .vec_next (lfsr_a_next)
  );

  vh_lfsr32 #(.INIT(SEED_B)) u_lfsr_b (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .step     (xfer && (state == RANDOM)),
    .seed     (SEED_B),
    .vec      (lfsr_b_vec),
    .vec_next (lfsr_b_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      vec_idx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_idx <= '0;
            a       <= corner_a(2'd0);
            b       <= corner_b(2'd0);
            if (NUM_VEC == 16'd0) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              vec_valid <= 1'b0;
            end else begin
              state     <= CORNER;
              busy      <= 1'b1;
              done      <= 1'b0;
              vec_valid <= 1'b1;
            end
          end
        end
        CORNER: begin
          if (xfer) begin
            vec_idx <= vec_idx + 16'd1;
            if (last) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              vec_valid <= 1'b0;
            end else if (vec_idx == 16'd3) begin
              // LFSRs have not stepped yet, so the first random vector is the seed.
              state <= RANDOM;
              a     <= lfsr_a_vec;
              b     <= lfsr_b_vec;
            end else begin
              a <= corner_a(vec_idx[1:0] + 2'd1);
              b <= corner_b(vec_idx[1:0] + 2'd1);
            end
          end
        end
        RANDOM: begin
          if (xfer) begin
            vec_idx <= vec_idx + 16'd1;
            if (last) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              vec_valid <= 1'b0;
            end else begin
              a <= lfsr_a_next;
              b <= lfsr_b_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vh_stim_gen.sv
// Randomized self-checking bench for vh_stim_gen; four instances cover the
// default run, a 2-vector run, an empty run and a zero-seed full run.
module tb_vh_stim_gen;

  logic        clk;
  logic        rst;
  logic        startS [4];
  logic        readyS [4];
  logic        busyS  [4];
  logic        doneS  [4];
  logic        validS [4];
  logic [29:0] aS     [4];
  logic [29:0] bS     [4];
  logic [15:0] idxS   [4];

  int          vecCount  = 0;
  int          missCount = 0;
  int          mIdx [4];
  logic [31:0] seedA [4] = '{32'h1, 32'h1, 32'h1, 32'h1};
  logic [31:0] seedB [4] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};

  vh_stim_gen #(.SEED(32'h1), .NUM_VEC(16'd1000)) u_main (
    .clk(clk), .rst(rst), .start(startS[0]), .busy(busyS[0]), .done(doneS[0]),
    .vec_valid(validS[0]), .vec_ready(readyS[0]), .a(aS[0]), .b(bS[0]), .vec_idx(idxS[0]));

  vh_stim_gen #(.SEED(32'h1), .NUM_VEC(16'd2)) u_two (
    .clk(clk), .rst(rst), .start(startS[1]), .busy(busyS[1]), .done(doneS[1]),
    .vec_valid(validS[1]), .vec_ready(readyS[1]), .a(aS[1]), .b(bS[1]), .vec_idx(idxS[1]));

  vh_stim_gen #(.SEED(32'h1), .NUM_VEC(16'd0)) u_zero (
    .clk(clk), .rst(rst), .start(startS[2]), .busy(busyS[2]), .done(doneS[2]),
    .vec_valid(validS[2]), .vec_ready(readyS[2]), .a(aS[2]), .b(bS[2]), .vec_idx(idxS[2]));

  vh_stim_gen #(.SEED(32'h0), .NUM_VEC(16'd1000)) u_zseed (
    .clk(clk), .rst(rst), .start(startS[3]), .busy(busyS[3]), .done(doneS[3]),
    .vec_valid(validS[3]), .vec_ready(readyS[3]), .a(aS[3]), .b(bS[3]), .vec_idx(idxS[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: vector k is a corner for k<4, else the seeds advanced k-4 times.
  function automatic void expVec(input int k, input int inst, output logic [29:0] ea, output logic [29:0] eb);
    logic [31:0] sa;
    logic [31:0] sb;
    case (k)
      0: begin ea = 30'h0;        eb = 30'h0;        end
      1: begin ea = 30'h3FFFFFFF; eb = 30'h3FFFFFFF; end
      2: begin ea = 30'h20840000; eb = 30'h1F7BFFFF; end
      3: begin ea = 30'h1F7BFFFF; eb = 30'h20840000; end
      default: begin
        sa = seedA[inst];
        sb = seedB[inst];
        for (int i = 0; i < k - 4; i++) begin
          sa = (sa << 1) ^ (sa[31] ? 32'h00400007 : 32'h0);
          sb = (sb << 1) ^ (sb[31] ? 32'h00400007 : 32'h0);
        end
        ea = sa[29:0];
        eb = sb[29:0];
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int inst);
    mIdx[inst]   = 0;
    startS[inst] = 1'b1;
    tick();
    startS[inst] = 1'b0;
  endtask

  // Drives random ready and checks the presented vector every cycle until n transfers.
  task automatic runVectors(input int inst, input int n, input int readyPct);
    int got    = 0;
    int cycles = 0;
    logic [29:0] ea;
    logic [29:0] eb;
    logic xfer;
    while (got < n && cycles < n * 20 + 20) begin
      readyS[inst] = ($urandom_range(0, 99) < readyPct);
      expVec(mIdx[inst], inst, ea, eb);
      checkOutput("valid", {31'd0, validS[inst]}, 32'd1);
      checkOutput("a", {2'd0, aS[inst]}, {2'd0, ea});
      checkOutput("b", {2'd0, bS[inst]}, {2'd0, eb});
      checkOutput("vec_idx", {16'd0, idxS[inst]}, mIdx[inst]);
      xfer = readyS[inst];
      tick();
      cycles++;
      if (xfer) begin
        mIdx[inst]++;
        got++;
      end
    end
    readyS[inst] = 1'b0;
    if (got < n) checkOutput("xfer_budget", got, n);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      startS[i] = 1'b0;
      readyS[i] = 1'b0;
      mIdx[i]   = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput("rst_busy", {31'd0, busyS[i]}, 32'd0);
      checkOutput("rst_done", {31'd0, doneS[i]}, 32'd0);
      checkOutput("rst_valid", {31'd0, validS[i]}, 32'd0);
      checkOutput("rst_a", {2'd0, aS[i]}, 32'd0);
      checkOutput("rst_b", {2'd0, bS[i]}, 32'd0);
      checkOutput("rst_idx", {16'd0, idxS[i]}, 32'd0);
    end
    rst = 1'b0;
    tick();

    // Default run: corners, stall on vector 2, then first random vectors.
    applyStimulus(0);
    checkOutput("valid_after_start", {31'd0, validS[0]}, 32'd1);
    checkOutput("busy_after_start", {31'd0, busyS[0]}, 32'd1);
    runVectors(0, 2, 100);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_a", {2'd0, aS[0]}, 32'h20840000);
      checkOutput("stall_b", {2'd0, bS[0]}, 32'h1F7BFFFF);
      checkOutput("stall_idx", {16'd0, idxS[0]}, 32'd2);
      tick();
    end
    runVectors(0, 2, 100);
    checkOutput("rand0_a", {2'd0, aS[0]}, 32'h00000001);
    checkOutput("rand0_b", {2'd0, bS[0]}, 32'h3FFFFFFE);
    runVectors(0, 1, 100);
    checkOutput("rand1_a", {2'd0, aS[0]}, 32'h00000002);
    checkOutput("rand1_b", {2'd0, bS[0]}, 32'h3FBFFFFB);

    // Start pulse while in RANDOM must be ignored.
    startS[0] = 1'b1;
    runVectors(0, 1, 100);
    startS[0] = 1'b0;
    checkOutput("start_ignored_idx", {16'd0, idxS[0]}, 32'd6);
    checkOutput("start_ignored_busy", {31'd0, busyS[0]}, 32'd1);
    runVectors(0, 500 - mIdx[0], 70);

    // Abort at vector 500, then restart from vector 0 with reseeded LFSRs.
    checkOutput("pre_abort_idx", {16'd0, idxS[0]}, 32'd500);
    rst = 1'b1;
    #1;
    checkOutput("abort_valid", {31'd0, validS[0]}, 32'd0);
    checkOutput("abort_busy", {31'd0, busyS[0]}, 32'd0);
    checkOutput("abort_idx", {16'd0, idxS[0]}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(0);
    runVectors(0, 7, 80);

    // Two-vector run, then a restart from DONE.
    applyStimulus(1);
    runVectors(1, 2, 60);
    for (int i = 0; i < 3; i++) begin
      readyS[1] = 1'b1;
      checkOutput("two_valid_low", {31'd0, validS[1]}, 32'd0);
      tick();
    end
    readyS[1] = 1'b0;
    checkOutput("two_done", {31'd0, doneS[1]}, 32'd1);
    checkOutput("two_busy", {31'd0, busyS[1]}, 32'd0);
    checkOutput("two_idx", {16'd0, idxS[1]}, 32'd2);
    applyStimulus(1);
    checkOutput("restart_done", {31'd0, doneS[1]}, 32'd0);
    checkOutput("restart_busy", {31'd0, busyS[1]}, 32'd1);
    checkOutput("restart_idx", {16'd0, idxS[1]}, 32'd0);

    // Empty run goes straight to DONE.
    readyS[2] = 1'b1;
    applyStimulus(2);
    checkOutput("empty_done", {31'd0, doneS[2]}, 32'd1);
    checkOutput("empty_busy", {31'd0, busyS[2]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("empty_valid", {31'd0, validS[2]}, 32'd0);
      tick();
    end
    readyS[2] = 1'b0;

    // Zero seed, full 1000-vector run.
    applyStimulus(3);
    runVectors(3, 4, 100);
    checkOutput("zseed_a", {2'd0, aS[3]}, 32'h00000001);
    checkOutput("zseed_b", {2'd0, bS[3]}, 32'h3FFFFFFF);
    runVectors(3, 996, 60);
    tick();
    checkOutput("full_done", {31'd0, doneS[3]}, 32'd1);
    checkOutput("full_idx", {16'd0, idxS[3]}, 32'd1000);
    checkOutput("full_valid", {31'd0, validS[3]}, 32'd0);
    checkOutput("full_busy", {31'd0, busyS[3]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
